apu_serial_loader: RTL and testbench

// - Upstream stage of the chiptune APU: receives 8N1 serial at 300 baud on the 4800 Hz clock.
// - Frames byte pairs (address, data) and writes the eight APU registers (pulse 1: 0-3, pulse 2: 4-7).
// - Replaces the sck-driven loader: one clock domain, oversampled RX, with packet timeout and error recovery.
// - Emits a one-cycle write strobe so the pulse channels can reload length/envelope on reg_3/reg_7 writes.

---
 rtl/apu_pkg.sv | 22 ++
 rtl/uart_rx_byte.sv | 117 +++++++++++
 rtl/apu_serial_loader.sv | 101 ++++++++++
 tb/tb_apu_serial_loader.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared constants and state encodings for the chiptune APU serial loader.
package apu_pkg;

    localparam logic [3:0] SYNC_NIBBLE  = 4'hA;
    localparam int         APU_CLK_HZ   = 4800;
    localparam int         BAUD         = 300;
    localparam int         NUM_APU_REGS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    typedef enum logic {
        P_ADDR,
        P_DATA
    } pkt_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampled 8N1 receiver: two-flop synchroniser, start-bit glitch
// rejection, LSB-first data capture and stop-bit checking with a break
// state that keeps a held-low line from re-triggering.
module uart_rx_byte
    import apu_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int             TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  LAST_TICK = TW'(OVERSAMPLE - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    rx_state_e     state_q;
    logic [TW-1:0] tick_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          byte_valid_q;
    logic          frame_err_q;

    assign rx_s = sync_q[1];

    // Synchronise the asynchronous line and keep a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx};
            prev_q <= rx_s;
        end
    end

    // Receive state machine with registered valid/error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (prev_q && !rx_s) begin
                        state_q <= START;
                        tick_q  <= '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_TICK) begin
                        tick_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == LAST_TICK) begin
                        tick_q  <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == LAST_TICK) begin
                        tick_q <= '0;
                        if (rx_s) begin
                            byte_valid_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/apu_serial_loader.sv
// Frames (address, data) byte pairs from the serial receiver into the
// eight APU registers, with a packet timeout and frame-error abort.
module apu_serial_loader
    import apu_pkg::*;
#(
    parameter int OVERSAMPLE   = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] apu_reg_0,
    output logic [7:0] apu_reg_1,
    output logic [7:0] apu_reg_2,
    output logic [7:0] apu_reg_3,
    output logic [7:0] apu_reg_4,
    output logic [7:0] apu_reg_5,
    output logic [7:0] apu_reg_6,
    output logic [7:0] apu_reg_7,
    output logic       wr_stb,
    output logic [2:0] wr_addr,
    output logic       frame_err
);

    localparam int            TIMEOUT_CYCLES = TIMEOUT_BITS * OVERSAMPLE;
    localparam int            CW             = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LAST   = CW'(TIMEOUT_CYCLES - 1);

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          rx_frame_err;

    pkt_state_e    pkt_q;
    logic [2:0]    addr_q;
    logic [CW-1:0] to_cnt_q;
    logic          wr_stb_q;
    logic [2:0]    wr_addr_q;
    logic [7:0]    regs_q [NUM_APU_REGS];

    uart_rx_byte #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (rx_frame_err)
    );

    // Packet framing, timeout and register file; a data byte beats a coincident timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q     <= P_ADDR;
            addr_q    <= '0;
            to_cnt_q  <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            for (int i = 0; i < NUM_APU_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            wr_stb_q <= 1'b0;
            case (pkt_q)
                P_ADDR: begin
                    if (byte_valid && (byte_data[7:4] == SYNC_NIBBLE)) begin
                        addr_q   <= byte_data[2:0];
                        to_cnt_q <= '0;
                        pkt_q    <= P_DATA;
                    end
                end
                P_DATA: begin
                    if (byte_valid) begin
                        regs_q[addr_q] <= byte_data;
                        wr_stb_q       <= 1'b1;
                        wr_addr_q      <= addr_q;
                        pkt_q          <= P_ADDR;
                    end else if (rx_frame_err || (to_cnt_q == TIMEOUT_LAST)) begin
                        pkt_q <= P_ADDR;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: pkt_q <= P_ADDR;
            endcase
        end
    end

    assign apu_reg_0 = regs_q[0];
    assign apu_reg_1 = regs_q[1];
    assign apu_reg_2 = regs_q[2];
    assign apu_reg_3 = regs_q[3];
    assign apu_reg_4 = regs_q[4];
    assign apu_reg_5 = regs_q[5];
    assign apu_reg_6 = regs_q[6];
    assign apu_reg_7 = regs_q[7];
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = rx_frame_err;

endmodule

// File: tb/tb_apu_serial_loader.sv
// Directed bench for apu_serial_loader: sends 8N1 frames at 16 clk/bit
// and checks the register file, write strobe and frame-error pulses.
module tb_apu_serial_loader;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] apu_reg_0, apu_reg_1, apu_reg_2, apu_reg_3;
    logic [7:0] apu_reg_4, apu_reg_5, apu_reg_6, apu_reg_7;
    logic       wr_stb;
    logic [2:0] wr_addr;
    logic       frame_err;

    logic [7:0] regs_w [8];
    logic [7:0] exp_regs [8];

    int vectors     = 0;
    int miscompares = 0;

    int         stb_count = 0;
    int         fe_count  = 0;
    logic [2:0] mon_addr  = 3'd0;
    logic [7:0] mon_val   = 8'h00;

    apu_serial_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .apu_reg_0 (apu_reg_0),
        .apu_reg_1 (apu_reg_1),
        .apu_reg_2 (apu_reg_2),
        .apu_reg_3 (apu_reg_3),
        .apu_reg_4 (apu_reg_4),
        .apu_reg_5 (apu_reg_5),
        .apu_reg_6 (apu_reg_6),
        .apu_reg_7 (apu_reg_7),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    assign regs_w[0] = apu_reg_0;
    assign regs_w[1] = apu_reg_1;
    assign regs_w[2] = apu_reg_2;
    assign regs_w[3] = apu_reg_3;
    assign regs_w[4] = apu_reg_4;
    assign regs_w[5] = apu_reg_5;
    assign regs_w[6] = apu_reg_6;
    assign regs_w[7] = apu_reg_7;

    always #5 clk = ~clk;

    // Count strobe/error pulses and capture what was written on each strobe.
    always @(negedge clk) begin
        if (wr_stb) begin
            stb_count = stb_count + 1;
            mon_addr  = wr_addr;
            mon_val   = regs_w[wr_addr];
        end
        if (frame_err) begin
            fe_count = fe_count + 1;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (OS) @(negedge clk);
        end
        rx = stop_bit;
        repeat (OS) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (regs_w[i] !== exp_regs[i]) begin
                miscompares++;
                $display("FAIL reset_reg%0d: got %h expected %h", i, regs_w[i], exp_regs[i]);
            end
        end
        vectors++;
        if (wr_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wr_stb: got %b expected 0", wr_stb);
        end
        vectors++;
        if (wr_addr !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr);
        end
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_err: got %b expected 0", frame_err);
        end
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_basic_write;
        int s0;
        s0 = stb_count;
        send_byte(8'hA3, 1'b1);
        send_byte(8'h5C, 1'b1);
        idle(4);
        exp_regs[3] = 8'h5C;
        vectors++;
        if (stb_count - s0 !== 1) begin
            miscompares++;
            $display("FAIL basic_stb_count: got %0d expected 1", stb_count - s0);
        end
        vectors++;
        if (mon_addr !== 3'd3) begin
            miscompares++;
            $display("FAIL basic_wr_addr: got %0d expected 3", mon_addr);
        end
        vectors++;
        if (mon_val !== 8'h5C) begin
            miscompares++;
            $display("FAIL basic_value_at_stb: got %h expected 5c", mon_val);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (regs_w[i] !== exp_regs[i]) begin
                miscompares++;
                $display("FAIL basic_reg%0d: got %h expected %h", i, regs_w[i], exp_regs[i]);
            end
        end
    endtask

    task automatic test_non_sync;
        int s0;
        s0 = stb_count;
        send_byte(8'h12, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h7F, 1'b1);
        idle(4);
        exp_regs[5] = 8'h7F;
        vectors++;
        if (stb_count - s0 !== 1) begin
            miscompares++;
            $display("FAIL nonsync_stb_count: got %0d expected 1", stb_count - s0);
        end
        vectors++;
        if (mon_addr !== 3'd5) begin
            miscompares++;
            $display("FAIL nonsync_wr_addr: got %0d expected 5", mon_addr);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (regs_w[i] !== exp_regs[i]) begin
                miscompares++;
                $display("FAIL nonsync_reg%0d: got %h expected %h", i, regs_w[i], exp_regs[i]);
            end
        end
    endtask

    task automatic test_timeout;
        int s0;
        s0 = stb_count;
        send_byte(8'hA1, 1'b1);
        idle(400);
        send_byte(8'h33, 1'b1);
        idle(4);
        vectors++;
        if (stb_count - s0 !== 0) begin
            miscompares++;
            $display("FAIL timeout_stb_count: got %0d expected 0", stb_count - s0);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (regs_w[i] !== exp_regs[i]) begin
                miscompares++;
                $display("FAIL timeout_reg%0d: got %h expected %h", i, regs_w[i], exp_regs[i]);
            end
        end
    endtask

    task automatic test_glitch;
        int s0;
        int f0;
        s0 = stb_count;
        f0 = fe_count;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(200);
        vectors++;
        if (stb_count - s0 !== 0) begin
            miscompares++;
            $display("FAIL glitch_stb_count: got %0d expected 0", stb_count - s0);
        end
        vectors++;
        if (fe_count - f0 !== 0) begin
            miscompares++;
            $display("FAIL glitch_frame_err_count: got %0d expected 0", fe_count - f0);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (regs_w[i] !== exp_regs[i]) begin
                miscompares++;
                $display("FAIL glitch_reg%0d: got %h expected %h", i, regs_w[i], exp_regs[i]);
            end
        end
    endtask

    task automatic test_frame_err;
        int s0;
        int f0;
        s0 = stb_count;
        f0 = fe_count;
        send_byte(8'hA2, 1'b1);
        // Data byte whose stop bit is low, then the line stays low.
        rx = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (OS) @(negedge clk);
        end
        rx = 1'b0;
        repeat (200) @(negedge clk);
        idle(20);
        vectors++;
        if (fe_count - f0 !== 1) begin
            miscompares++;
            $display("FAIL ferr_pulse_count: got %0d expected 1", fe_count - f0);
        end
        vectors++;
        if (stb_count - s0 !== 0) begin
            miscompares++;
            $display("FAIL ferr_stb_count: got %0d expected 0", stb_count - s0);
        end
        vectors++;
        if (apu_reg_2 !== exp_regs[2]) begin
            miscompares++;
            $display("FAIL ferr_reg2_held: got %h expected %h", apu_reg_2, exp_regs[2]);
        end
        s0 = stb_count;
        send_byte(8'hA2, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(4);
        exp_regs[2] = 8'h44;
        vectors++;
        if (stb_count - s0 !== 1) begin
            miscompares++;
            $display("FAIL ferr_recover_stb_count: got %0d expected 1", stb_count - s0);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (regs_w[i] !== exp_regs[i]) begin
                miscompares++;
                $display("FAIL ferr_reg%0d: got %h expected %h", i, regs_w[i], exp_regs[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet;
        int s0;
        logic [7:0] d;
        d = 8'h99;
        send_byte(8'hA7, 1'b1);
        s0 = stb_count;
        rx = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (OS) @(negedge clk);
        end
        rx = d[4];
        repeat (OS / 2) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(200);
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        vectors++;
        if (stb_count - s0 !== 0) begin
            miscompares++;
            $display("FAIL midrst_stb_count: got %0d expected 0", stb_count - s0);
        end
        vectors++;
        if (wr_addr !== 3'd0) begin
            miscompares++;
            $display("FAIL midrst_wr_addr: got %0d expected 0", wr_addr);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (regs_w[i] !== exp_regs[i]) begin
                miscompares++;
                $display("FAIL midrst_reg%0d: got %h expected %h", i, regs_w[i], exp_regs[i]);
            end
        end
        send_byte(8'hA7, 1'b1);
        send_byte(8'h99, 1'b1);
        idle(4);
        exp_regs[7] = 8'h99;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (regs_w[i] !== exp_regs[i]) begin
                miscompares++;
                $display("FAIL midrst_after_reg%0d: got %h expected %h", i, regs_w[i], exp_regs[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int s0;
        s0 = stb_count;
        // 0xA8 and 0xAC exercise the ignored bit 3; 0xAB is data despite its sync nibble.
        send_byte(8'hA8, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'hAC, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hA6, 1'b1);
        send_byte(8'h33, 1'b1);
        idle(4);
        exp_regs[0] = 8'h11;
        exp_regs[4] = 8'hAB;
        exp_regs[6] = 8'h33;
        vectors++;
        if (stb_count - s0 !== 3) begin
            miscompares++;
            $display("FAIL b2b_stb_count: got %0d expected 3", stb_count - s0);
        end
        vectors++;
        if (mon_addr !== 3'd6) begin
            miscompares++;
            $display("FAIL b2b_last_wr_addr: got %0d expected 6", mon_addr);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (regs_w[i] !== exp_regs[i]) begin
                miscompares++;
                $display("FAIL b2b_reg%0d: got %h expected %h", i, regs_w[i], exp_regs[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_non_sync();
        test_timeout();
        test_glitch();
        test_frame_err();
        test_reset_mid_packet();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
